ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_pkg.sv | 37 +++
 rtl/frame_edge_detect.sv | 26 ++
 rtl/ball_motion.sv | 110 +++++++++++
 tb/tb_ball_motion.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types, key codes and screen defaults for the ball motion block.
package ball_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // USB HID usage codes for the steering keys.
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [2:0] {
    DirStop  = 3'd0,
    DirLeft  = 3'd1,
    DirRight = 3'd2,
    DirUp    = 3'd3,
    DirDown  = 3'd4
  } dir_t;

  // Moves pos one step down (dec) or up (inc), saturating inside [lo, hi].
  // Comparisons are arranged so no intermediate value can wrap.
  function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic dec,
                                            input logic inc, input logic [9:0] lo,
                                            input logic [9:0] hi, input logic [9:0] step);
    logic [9:0] res;
    res = pos;
    if (dec) begin
      res = (pos < lo + step) ? lo : pos - step;
    end else if (inc) begin
      res = (pos > hi - step) ? hi : pos + step;
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Two-flop synchronizer for the frame strobe plus a one-cycle rising-edge pulse.
module frame_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Driven only by flops, so the pulse is glitch-free and zero during reset.
  assign tick_o = sync2_q & ~hist_q;

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction update once per frame with edge bounce and clamping.
// Define BALL_KEY_CTRL_EN for keyboard steering; otherwise the ball bounces on its own.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned X_CENTER = SCREEN_W / 2,
  parameter int unsigned Y_CENTER = SCREEN_H / 2,
  parameter int unsigned X_MAX    = SCREEN_W - 1,
  parameter int unsigned Y_MAX    = SCREEN_H - 1,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SIZE     = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic [2:0] Dir,
  output logic       frame_tick
);

  localparam logic [9:0] Size  = 10'(SIZE);
  localparam logic [9:0] Step  = 10'(STEP);
  localparam logic [9:0] XMax  = 10'(X_MAX);
  localparam logic [9:0] YMax  = 10'(Y_MAX);
  localparam logic [9:0] XHi   = 10'(X_MAX - SIZE);
  localparam logic [9:0] YHi   = 10'(Y_MAX - SIZE);
  localparam logic [9:0] XInit = 10'(X_CENTER);
  localparam logic [9:0] YInit = 10'(Y_CENTER);

`ifdef BALL_KEY_CTRL_EN
  localparam dir_t DirReset = DirStop;
`else
  localparam dir_t DirReset = DirDown;
`endif

  dir_t       dir_q, dir_d, dir_key;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       tick;

  frame_edge_detect u_frame_edge_detect (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .sig_i  (frame_clk),
    .tick_o (tick)
  );

`ifdef BALL_KEY_CTRL_EN
  always_comb begin
    dir_key = dir_q;
    case (keycode)
      KEY_A:     dir_key = DirLeft;
      KEY_D:     dir_key = DirRight;
      KEY_W:     dir_key = DirUp;
      KEY_S:     dir_key = DirDown;
      KEY_SPACE: dir_key = DirStop;
      default:   dir_key = dir_q;
    endcase
  end
`else
  logic unused_keycode;
  assign unused_keycode = ^keycode;
  assign dir_key        = dir_q;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_q <= DirReset;
      x_q   <= XInit;
      y_q   <= YInit;
    end else begin
      dir_q <= dir_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  // Bounce tests use the current direction and take priority over any key.
  always_comb begin
    dir_d = dir_q;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (dir_q == DirRight && x_q + Size >= XMax) begin
        dir_d = DirLeft;
      end else if (dir_q == DirLeft && x_q <= Size) begin
        dir_d = DirRight;
      end else if (dir_q == DirUp && y_q <= Size) begin
        dir_d = DirDown;
      end else if (dir_q == DirDown && y_q + Size >= YMax) begin
        dir_d = DirUp;
      end else begin
        dir_d = dir_key;
      end
      x_d = step_clamp(x_q, dir_d == DirLeft, dir_d == DirRight, Size, XHi, Step);
      y_d = step_clamp(y_q, dir_d == DirUp, dir_d == DirDown, Size, YHi, Step);
    end
  end

  always_comb begin
    BallX      = x_q;
    BallY      = y_q;
    BallS      = Size;
    Dir        = dir_q;
    frame_tick = tick;
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with default parameters; covers both key-control builds.
module tb_ball_motion;

  localparam int DStop  = 0;
  localparam int DLeft  = 1;
  localparam int DRight = 2;
  localparam int DUp    = 3;
  localparam int DDown  = 4;

`ifdef BALL_KEY_CTRL_EN
  localparam int DReset = DStop;
`else
  localparam int DReset = DDown;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] ball_x, ball_y, ball_s;
  logic [2:0] dir;
  logic       frame_tick;
  logic       tick_seen;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .BallX      (ball_x),
    .BallY      (ball_y),
    .BallS      (ball_s),
    .Dir        (dir),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int x, input int y, input int d);
    check({tag, "_x"}, 32'(ball_x), 32'(x));
    check({tag, "_y"}, 32'(ball_y), 32'(y));
    check({tag, "_dir"}, 32'(dir), 32'(d));
  endtask

  // One frame strobe; optionally checks the pulse lands in the third cycle only.
  task automatic tick_frame(input bit chk_lat);
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); if (chk_lat) check("tick_c2", 32'(frame_tick), 32'd0);
    @(negedge clk); if (chk_lat) check("tick_c3", 32'(frame_tick), 32'd1);
    @(negedge clk); if (chk_lat) check("tick_c4", 32'(frame_tick), 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_frame(1'b0);
  endtask

  task automatic watch_idle(input int cycles);
    tick_seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      tick_seen = tick_seen | frame_tick;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_state("rst", 320, 240, DReset);
    check("rst_s", 32'(ball_s), 32'd4);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    watch_idle(10);
    check("idle_tick", 32'(tick_seen), 32'd0);
    check_state("idle", 320, 240, DReset);
    check("idle_s", 32'(ball_s), 32'd4);

`ifdef BALL_KEY_CTRL_EN
    keycode = 8'h07;
    tick_frame(1'b1);
    check_state("right1", 321, 240, DRight);
    run_ticks(313);
    check_state("right_634", 634, 240, DRight);
    tick_frame(1'b0);
    check_state("right_635", 635, 240, DRight);
    tick_frame(1'b0);
    check_state("bounce_x", 634, 240, DLeft);
    keycode = 8'h55;
    tick_frame(1'b0);
    check_state("other_key", 633, 240, DLeft);
    keycode = 8'h1A;
    tick_frame(1'b0);
    check_state("up1", 633, 239, DUp);
    run_ticks(235);
    check_state("up_top", 633, 4, DUp);
    tick_frame(1'b0);
    check_state("bounce_y", 633, 5, DDown);
    keycode = 8'h2C;
    tick_frame(1'b0);
    check_state("stop1", 633, 5, DStop);
    run_ticks(5);
    check_state("stop5", 633, 5, DStop);
    keycode = 8'h16;
    tick_frame(1'b0);
    check_state("down1", 633, 6, DDown);
    keycode = 8'h00;
`else
    keycode = 8'h07;
    tick_frame(1'b1);
    check_state("auto1", 320, 241, DDown);
    run_ticks(233);
    check_state("auto_474", 320, 474, DDown);
    tick_frame(1'b0);
    check_state("auto_clamp", 320, 475, DDown);
    tick_frame(1'b0);
    check_state("bounce_bot", 320, 474, DUp);
    keycode = 8'h2C;
    tick_frame(1'b0);
    check_state("key_ignored", 320, 473, DUp);
    run_ticks(468);
    check_state("auto_5", 320, 5, DUp);
    tick_frame(1'b0);
    check_state("auto_top", 320, 4, DUp);
    tick_frame(1'b0);
    check_state("bounce_top", 320, 5, DDown);
`endif

    // Reset between frame_clk rise and the tick aborts that update.
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_state("midrst", 320, 240, DReset);
    check("midrst_tick", 32'(frame_tick), 32'd0);
    frame_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_idle(8);
    check("midrst_idle_tick", 32'(tick_seen), 32'd0);
    check_state("midrst_idle", 320, 240, DReset);

    tick_frame(1'b1);
`ifdef BALL_KEY_CTRL_EN
    check_state("fresh", 320, 240, DStop);
`else
    check_state("fresh", 320, 241, DDown);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
